// File: rtl/des_key_sched.sv
// Iterative DES key schedule: PC-1 on start, per-round C/D rotation, PC-2 per subkey.
// Streams K1..K16 (encrypt) or K16..K1 (decrypt) under a valid/ready handshake.
module des_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [63:0] key,
  input  logic        dec,
  input  logic        k_ready,
  output logic [47:0] k,
  output logic        k_valid,
  output logic [3:0]  rnd,
  output logic        ack
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GEN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // DES bit numbers (1 = MSB), first table entry in the most significant slot
  localparam logic [335:0] PC1_TBL = {
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [287:0] PC2_TBL = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [55:0] pc1(input logic [63:0] kin);
    logic [55:0] o;
    logic [5:0]  p;
    o = 56'd0;
    for (int i = 0; i < 56; i++) begin
      p = PC1_TBL[(55 - i) * 6 +: 6];
      o[55 - i] = kin[6'd63 - (p - 6'd1)];
    end
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cdin);
    logic [47:0] o;
    logic [5:0]  p;
    o = 48'd0;
    for (int i = 0; i < 48; i++) begin
      p = PC2_TBL[(47 - i) * 6 +: 6];
      o[47 - i] = cdin[6'd56 - p];
    end
    return o;
  endfunction

  function automatic logic [27:0] rot_half(input logic [27:0] h, input logic right, input logic two);
    logic [27:0] o;
    case ({right, two})
      2'b00:   o = {h[26:0], h[27]};
      2'b01:   o = {h[25:0], h[27:26]};
      2'b10:   o = {h[0], h[27:1]};
      2'b11:   o = {h[1:0], h[27:2]};
      default: o = h;
    endcase
    return o;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  r_q, r_d;
  logic        dec_q, dec_d;
  logic [47:0] k_q, k_d;
  logic        k_valid_q, k_valid_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        ack_q, ack_d;
  logic [55:0] pc_s;
  logic        one_s;

  // Parity bits of the key never reach the schedule.
  logic unused_parity_s;
  assign unused_parity_s = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};

  // Next-state logic; outputs are precomputed from next state so they leave flops.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    r_d     = r_q;
    dec_d   = dec_q;
    pc_s    = pc1(key);
    // Single-bit shift after rounds 1, 8 and 15 (both directions share this set)
    one_s   = (r_q == 4'd0) || (r_q == 4'd7) || (r_q == 4'd14);
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cd_d    = dec ? pc_s : {rot_half(pc_s[55:28], 1'b0, 1'b0), rot_half(pc_s[27:0], 1'b0, 1'b0)};
          r_d     = 4'd0;
          dec_d   = dec;
          state_d = ST_GEN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GEN: begin
        if (k_ready) begin
          r_d = r_q + 4'd1;
          if (r_q == 4'd15) begin
            state_d = ST_DONE;
          end else begin
            cd_d = {rot_half(cd_q[55:28], dec_q, ~one_s), rot_half(cd_q[27:0], dec_q, ~one_s)};
          end
        end else begin
          state_d = ST_GEN;
        end
      end
      ST_DONE: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    k_valid_d = (state_d == ST_GEN);
    k_d       = k_valid_d ? pc2(cd_d) : 48'd0;
    rnd_d     = k_valid_d ? r_d : 4'd0;
    ack_d     = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cd_q      <= 56'd0;
      r_q       <= 4'd0;
      dec_q     <= 1'b0;
      k_q       <= 48'd0;
      k_valid_q <= 1'b0;
      rnd_q     <= 4'd0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      r_q       <= r_d;
      dec_q     <= dec_d;
      k_q       <= k_d;
      k_valid_q <= k_valid_d;
      rnd_q     <= rnd_d;
      ack_q     <= ack_d;
    end
  end

  assign k       = k_q;
  assign k_valid = k_valid_q;
  assign rnd     = rnd_q;
  assign ack     = ack_q;

endmodule
